// File: rtl/gpio_port_ctrl_if.sv
// CPU-side register bus for the GPIO port controller.
// The CPU drives address, strobes and write data; the controller returns registered read data.
interface gpio_port_ctrl_if;
  logic [2:0]  addr;
  logic        we;
  logic        re;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, we, re, be, wdata, input rdata);
  modport slave  (input addr, we, re, be, wdata, output rdata);
endinterface

// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers, tri-state pin drive,
// synchronised pin inputs and sticky rise/fall edge status feeding a level interrupt.
module gpio_port_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  gpio_port_ctrl_if.slave   bus,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  ports
);

  localparam logic [2:0] A_DIR     = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_EDGE_ST = 3'd5;

  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] outr;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_st;
  logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] prev;
  logic [31:0]      rdata_q;

  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_word;

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                   input logic [WIDTH-1:0] new_v,
                                                   input logic [WIDTH-1:0] mask);
    merge_bytes = (old_v & ~mask) | (new_v & mask);
  endfunction

  // Each pin follows the byte lane it lives in; data bits above WIDTH are dropped.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign wmask[i] = bus.be[i/8];
    assign ports[i] = dir[i] ? outr[i] : 1'bz;
  end

  assign wbits = bus.wdata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^bus.wdata[31:WIDTH];
  end

  assign in_s     = sync_pipe[SYNC_STAGES-1];
  assign edge_set = (in_s & ~prev & rise_en) | (~in_s & prev & fall_en);
  assign edge_clr = (bus.we && bus.addr == A_EDGE_ST) ? (wbits & wmask) : '0;
  assign irq      = |edge_st;
  assign bus.rdata = rdata_q;

  always_comb begin
    rd_word = '0;
    case (bus.addr)
      A_DIR:     rd_word[WIDTH-1:0] = dir;
      A_OUT:     rd_word[WIDTH-1:0] = outr;
      A_IN:      rd_word[WIDTH-1:0] = in_s;
      A_RISE_EN: rd_word[WIDTH-1:0] = rise_en;
      A_FALL_EN: rd_word[WIDTH-1:0] = fall_en;
      A_EDGE_ST: rd_word[WIDTH-1:0] = edge_st;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir     <= '0;
      outr    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      edge_st <= '0;
      prev    <= '0;
      rdata_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
    end else begin
      if (bus.we) begin
        case (bus.addr)
          A_DIR:     dir     <= merge_bytes(dir,     wbits, wmask);
          A_OUT:     outr    <= merge_bytes(outr,    wbits, wmask);
          A_RISE_EN: rise_en <= merge_bytes(rise_en, wbits, wmask);
          A_FALL_EN: fall_en <= merge_bytes(fall_en, wbits, wmask);
          default:   ;
        endcase
      end
      // A new edge beats a W1C on the same bit so no event is ever lost.
      edge_st <= (edge_st & ~edge_clr) | edge_set;
      // Read mux samples pre-write register values, giving read-before-write on collisions.
      if (bus.re) rdata_q <= rd_word;
      // --- input synchroniser stages, then one-cycle history for edge detection ---
      sync_pipe[0] <= ports;
      for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
      prev <= in_s;
    end
  end

endmodule
